is2vid_mode_banks: RTL and testbench
====================================

# is2vid_mode_banks

Mode register bank for the ImageStream-to-video output path. It sits between the Avalon-MM control slave and the outgoing timing state machine. It stores per-mode video timing written over the control port's trigger/acknowledge handshake, and matches incoming ImageStream control packets against the stored modes. It raises `mode_change` / `mode_match` to the control block and presents the selected mode's timing to the output generator, swapping only at frame boundaries.

## Interface
- `NO_OF_MODES`, default 4: number of timing banks (1..16).
- `SEL_WIDTH`, default 2: bank-select width. Must satisfy 2^SEL_WIDTH >= NO_OF_MODES.
- `clk` input, 1: the single clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `write_trigger` input, 1: Avalon write to address >= 5, from the control block. Held until acknowledged.
- `av_address` input, 8: Avalon word address.
- `av_writedata` input, 16: Avalon write data.
- `av_write_ack` output, 1: one-cycle write acknowledge to the control block.
- `is_ctrl_valid` input, 1: one-cycle strobe; incoming control-packet fields are valid.
- `is_width` input, 16: incoming active width.
- `is_height` input, 16: incoming active height.
- `is_interlaced` input, 1: incoming interlaced flag.
- `frame_start` input, 1: one-cycle strobe from the output state machine at its frame boundary.
- `mode_change` output, 1: one-cycle pulse when `mode_match` is updated with a new value.
- `mode_match` output, NO_OF_MODES: one-hot or all-zero match vector.
- `out_valid` output, 1: the output timing fields hold a valid mode.
- `out_interlaced` output, 1: interlaced flag of the selected mode.
- `out_h_active`, `out_h_front`, `out_h_sync`, `out_h_back` output, 16 each: horizontal timing of the selected mode.
- `out_v_active`, `out_v_front`, `out_v_sync`, `out_v_back` output, 16 each: vertical timing of the selected mode.

## Operation
- Address map (word addresses):
  - 5: bank select.
  - 6: h_active.
  - 7: v_active.
  - 8: interlaced (bit 0).
  - 9–11: h_front, h_sync, h_back.
  - 12–14: v_front, v_sync, v_back.
  - 15: mode_valid (bit 0).
  - Writes to addresses >15 are acknowledged and discarded.
- Bank select write:
  - A value >= NO_OF_MODES is acknowledged and ignored; the previous selection is kept.
  - Otherwise `wr_bank` <= `av_writedata[SEL_WIDTH-1:0]`.
- Addresses 6–15 write into bank `wr_bank`. Single-bit fields take bit 0 only.
- Write handshake:
  - `ack_reg` <= `write_trigger` & ~`ack_reg`; `av_write_ack` = `ack_reg`.
  - The commit occurs on the clock edge at which `ack_reg` is 1, so each write commits exactly once.
  - A trigger held back-to-back across two writes is acknowledged every second cycle.
- Matching, on `is_ctrl_valid`:
  - Bank i matches when `mode_valid[i]` is set and width, height and interlaced all equal the incoming fields.
  - The lowest matching index wins.
  - `mode_match` <= one-hot(winner), or zero when nothing matches.
  - `mode_change` pulses in the same cycle `mode_match` updates, but only if the new vector differs from the old one.
  - `pending_sel` <= winner; `pending_ok` <= (any match).
- On `frame_start`:
  - If `pending_ok`, the output fields load from bank `pending_sel` and `out_valid` <= 1.
  - If not, `out_valid` <= 0 and the output fields hold their values.
- After loading, the output fields are a snapshot. Later writes to that bank reach the outputs only at the next `frame_start`.
- Simultaneous events:
  - A write commit and `is_ctrl_valid` in the same cycle: matching uses pre-write bank contents.
  - A write commit and `frame_start` in the same cycle: the output loads pre-write contents.
  - `is_ctrl_valid` and `frame_start` in the same cycle: `frame_start` uses the old `pending_sel` / `pending_ok`.
- Clearing `mode_valid` of the active bank has no effect until the next `is_ctrl_valid` followed by `frame_start`.

## Timing
- Reset values: all bank registers, `mode_valid`, `wr_bank`, `pending_sel` and `pending_ok` are 0. Outputs `av_write_ack`, `mode_change`, `mode_match`, `out_valid` and all `out_*` fields are 0.
- Write latency: `write_trigger` rises in cycle N; `av_write_ack` = 1 in cycle N+1; the data is visible in the bank in cycle N+2.
- Match latency: `is_ctrl_valid` in cycle N gives `mode_match` / `mode_change` in cycle N+1.
- Output latency: `frame_start` in cycle N gives the new `out_*` values in cycle N+1.
- Reset asserted mid-handshake: the ack is dropped and the write is lost. The control block's waitrequest stays high until the master retries.

## Test plan
- Reset mid-write: assert `write_trigger` to address 6, pull `rst_n` low in the ack cycle -> `av_write_ack` = 0 and bank 0 h_active = 0 after release.
- Write bank 1 = {1920, 1080, progressive, valid}, then `is_ctrl_valid` with 1920x1080p -> `mode_match` = 4'b0010 with a one-cycle `mode_change`. A `frame_start` then gives `out_h_active` = 1920 and `out_valid` = 1.
- Banks 0 and 2 both valid with 720x576i, then control packet 720x576i -> `mode_match` = 4'b0001. Repeat the same packet -> no `mode_change` pulse.
- Write 7 to bank select with NO_OF_MODES = 4, then write h_active = 100 -> the previous bank gets 100 and bank 3 is unchanged.
- Held `write_trigger` for two consecutive writes -> `av_write_ack` pulses at N+1 and N+3 and both values commit exactly once.
- Unmatched packet 640x480 -> `mode_match` = 0 with a `mode_change` pulse. At the next `frame_start`, `out_valid` = 0 and `out_h_active` keeps its old value.

Source files
------------

// File: rtl/is2vid_mode_banks.sv
// Mode register bank for the ImageStream-to-video output path.
// Ports: Avalon write (write_trigger/av_address/av_writedata/av_write_ack),
// ImageStream control fields (is_*), frame_start, match outputs, out_* timing.
module is2vid_mode_banks #(
   parameter int NO_OF_MODES = 4,
   parameter int SEL_WIDTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   write_trigger,
   input  logic [7:0]             av_address,
   input  logic [15:0]            av_writedata,
   output logic                   av_write_ack,
   input  logic                   is_ctrl_valid,
   input  logic [15:0]            is_width,
   input  logic [15:0]            is_height,
   input  logic                   is_interlaced,
   input  logic                   frame_start,
   output logic                   mode_change,
   output logic [NO_OF_MODES-1:0] mode_match,
   output logic                   out_valid,
   output logic                   out_interlaced,
   output logic [15:0]            out_h_active,
   output logic [15:0]            out_h_front,
   output logic [15:0]            out_h_sync,
   output logic [15:0]            out_h_back,
   output logic [15:0]            out_v_active,
   output logic [15:0]            out_v_front,
   output logic [15:0]            out_v_sync,
   output logic [15:0]            out_v_back
);

   logic [15:0] h_act [NO_OF_MODES];
   logic [15:0] h_fp  [NO_OF_MODES];
   logic [15:0] h_sw  [NO_OF_MODES];
   logic [15:0] h_bp  [NO_OF_MODES];
   logic [15:0] v_act [NO_OF_MODES];
   logic [15:0] v_fp  [NO_OF_MODES];
   logic [15:0] v_sw  [NO_OF_MODES];
   logic [15:0] v_bp  [NO_OF_MODES];
   logic [NO_OF_MODES-1:0] ilace;
   logic [NO_OF_MODES-1:0] mode_valid;

   logic [SEL_WIDTH-1:0]   wr_bank;
   logic [SEL_WIDTH-1:0]   pending_sel;
   logic                   pending_ok;
   logic                   ack_reg;

   logic [SEL_WIDTH-1:0]   win;
   logic                   any_hit;
   logic [NO_OF_MODES-1:0] new_match;

   assign av_write_ack = ack_reg;

   // Scan high to low so the lowest matching bank is the one left standing.
   always_comb begin
      win     = '0;
      any_hit = 1'b0;
      for (int i = NO_OF_MODES - 1; i >= 0; i--) begin
         if (mode_valid[i] && h_act[i] == is_width &&
             v_act[i] == is_height && ilace[i] == is_interlaced) begin
            win     = SEL_WIDTH'(i);
            any_hit = 1'b1;
         end
      end
      new_match = any_hit ? (NO_OF_MODES'(1) << win) : '0;
   end

   // Bank registers and write handshake; the commit happens on the
   // edge where the ack is already high, so each write lands once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_reg    <= 1'b0;
         wr_bank    <= '0;
         ilace      <= '0;
         mode_valid <= '0;
         for (int i = 0; i < NO_OF_MODES; i++) begin
            h_act[i] <= '0;
            h_fp[i]  <= '0;
            h_sw[i]  <= '0;
            h_bp[i]  <= '0;
            v_act[i] <= '0;
            v_fp[i]  <= '0;
            v_sw[i]  <= '0;
            v_bp[i]  <= '0;
         end
      end else begin
         ack_reg <= write_trigger & ~ack_reg;
         if (ack_reg) begin
            case (av_address)
               8'd5: begin
                  if (av_writedata < 16'(NO_OF_MODES))
                     wr_bank <= av_writedata[SEL_WIDTH-1:0];
               end
               8'd6:  h_act[wr_bank]      <= av_writedata;
               8'd7:  v_act[wr_bank]      <= av_writedata;
               8'd8:  ilace[wr_bank]      <= av_writedata[0];
               8'd9:  h_fp[wr_bank]       <= av_writedata;
               8'd10: h_sw[wr_bank]       <= av_writedata;
               8'd11: h_bp[wr_bank]       <= av_writedata;
               8'd12: v_fp[wr_bank]       <= av_writedata;
               8'd13: v_sw[wr_bank]       <= av_writedata;
               8'd14: v_bp[wr_bank]       <= av_writedata;
               8'd15: mode_valid[wr_bank] <= av_writedata[0];
               default: ;
            endcase
         end
      end
   end

   // Match tracking and frame-boundary output snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_change    <= 1'b0;
         mode_match     <= '0;
         pending_sel    <= '0;
         pending_ok     <= 1'b0;
         out_valid      <= 1'b0;
         out_interlaced <= 1'b0;
         out_h_active   <= '0;
         out_h_front    <= '0;
         out_h_sync     <= '0;
         out_h_back     <= '0;
         out_v_active   <= '0;
         out_v_front    <= '0;
         out_v_sync     <= '0;
         out_v_back     <= '0;
      end else begin
         mode_change <= 1'b0;
         if (is_ctrl_valid) begin
            mode_match  <= new_match;
            mode_change <= (new_match != mode_match);
            pending_sel <= win;
            pending_ok  <= any_hit;
         end
         if (frame_start) begin
            out_valid <= pending_ok;
            if (pending_ok) begin
               out_interlaced <= ilace[pending_sel];
               out_h_active   <= h_act[pending_sel];
               out_h_front    <= h_fp[pending_sel];
               out_h_sync     <= h_sw[pending_sel];
               out_h_back     <= h_bp[pending_sel];
               out_v_active   <= v_act[pending_sel];
               out_v_front    <= v_fp[pending_sel];
               out_v_sync     <= v_sw[pending_sel];
               out_v_back     <= v_bp[pending_sel];
            end
         end
      end
   end

endmodule

// File: tb/tb_is2vid_mode_banks.sv
// Directed testbench for is2vid_mode_banks.
// Each task drives one scenario and checks its own expected values.
module tb_is2vid_mode_banks;

   logic        clk;
   logic        rst_n;
   logic        write_trigger;
   logic [7:0]  av_address;
   logic [15:0] av_writedata;
   logic        av_write_ack;
   logic        is_ctrl_valid;
   logic [15:0] is_width;
   logic [15:0] is_height;
   logic        is_interlaced;
   logic        frame_start;
   logic        mode_change;
   logic [3:0]  mode_match;
   logic        out_valid;
   logic        out_interlaced;
   logic [15:0] out_h_active, out_h_front, out_h_sync, out_h_back;
   logic [15:0] out_v_active, out_v_front, out_v_sync, out_v_back;

   int tests;
   int fails;

   is2vid_mode_banks #(.NO_OF_MODES(4), .SEL_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .write_trigger(write_trigger), .av_address(av_address),
      .av_writedata(av_writedata), .av_write_ack(av_write_ack),
      .is_ctrl_valid(is_ctrl_valid), .is_width(is_width),
      .is_height(is_height), .is_interlaced(is_interlaced),
      .frame_start(frame_start), .mode_change(mode_change),
      .mode_match(mode_match), .out_valid(out_valid),
      .out_interlaced(out_interlaced),
      .out_h_active(out_h_active), .out_h_front(out_h_front),
      .out_h_sync(out_h_sync), .out_h_back(out_h_back),
      .out_v_active(out_v_active), .out_v_front(out_v_front),
      .out_v_sync(out_v_sync), .out_v_back(out_v_back)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single write; inputs change on negedge, outputs sampled on negedge.
   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      write_trigger = 1'b1;
      av_address    = a;
      av_writedata  = d;
      @(negedge clk);
      write_trigger = 1'b0;
      @(negedge clk);
   endtask

   task automatic pkt(input logic [15:0] w, input logic [15:0] h,
                      input logic il);
      @(negedge clk);
      is_ctrl_valid = 1'b1;
      is_width      = w;
      is_height     = h;
      is_interlaced = il;
      @(negedge clk);
      is_ctrl_valid = 1'b0;
   endtask

   task automatic fs();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      tests++;
      if (av_write_ack !== 1'b0 || mode_change !== 1'b0 ||
          mode_match !== 4'b0 || out_valid !== 1'b0 ||
          out_h_active !== 16'd0 || out_v_back !== 16'd0) begin
         fails++;
         $display("FAIL reset_outputs ack=%b chg=%b match=%b vld=%b ha=%0d vb=%0d want all 0",
                  av_write_ack, mode_change, mode_match, out_valid,
                  out_h_active, out_v_back);
      end
      @(negedge clk);
      write_trigger = 1'b1;
      av_address    = 8'd6;
      av_writedata  = 16'd1234;
      @(negedge clk);
      tests++;
      if (av_write_ack !== 1'b1) begin
         fails++;
         $display("FAIL reset_ack_before got %b want 1", av_write_ack);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (av_write_ack !== 1'b0) begin
         fails++;
         $display("FAIL reset_ack_dropped got %b want 0", av_write_ack);
      end
      write_trigger = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // Bank 0 h_active must still be 0: validate bank 0 and match 0x0p.
      wr(8'd15, 16'd1);
      pkt(16'd0, 16'd0, 1'b0);
      tests++;
      if (mode_match !== 4'b0001 || mode_change !== 1'b1) begin
         fails++;
         $display("FAIL reset_lost_write match=%b chg=%b want 0001/1",
                  mode_match, mode_change);
      end
      fs();
      tests++;
      if (out_valid !== 1'b1 || out_h_active !== 16'd0) begin
         fails++;
         $display("FAIL reset_bank0_hact vld=%b ha=%0d want 1/0",
                  out_valid, out_h_active);
      end
   endtask

   task automatic test_match();
      wr(8'd5, 16'd1);
      wr(8'd6, 16'd1920);
      wr(8'd7, 16'd1080);
      wr(8'd8, 16'd0);
      wr(8'd9, 16'd88);
      wr(8'd10, 16'd44);
      wr(8'd11, 16'd148);
      wr(8'd12, 16'd4);
      wr(8'd13, 16'd5);
      wr(8'd14, 16'd36);
      wr(8'd15, 16'd1);
      pkt(16'd1920, 16'd1080, 1'b0);
      tests++;
      if (mode_match !== 4'b0010 || mode_change !== 1'b1) begin
         fails++;
         $display("FAIL match_1080p match=%b chg=%b want 0010/1",
                  mode_match, mode_change);
      end
      @(negedge clk);
      tests++;
      if (mode_change !== 1'b0) begin
         fails++;
         $display("FAIL match_pulse_width chg=%b want 0", mode_change);
      end
      fs();
      tests++;
      if (out_valid !== 1'b1 || out_h_active !== 16'd1920 ||
          out_v_active !== 16'd1080 || out_interlaced !== 1'b0) begin
         fails++;
         $display("FAIL match_out vld=%b ha=%0d va=%0d il=%b want 1/1920/1080/0",
                  out_valid, out_h_active, out_v_active, out_interlaced);
      end
      tests++;
      if (out_h_front !== 16'd88 || out_h_sync !== 16'd44 ||
          out_h_back !== 16'd148 || out_v_front !== 16'd4 ||
          out_v_sync !== 16'd5 || out_v_back !== 16'd36) begin
         fails++;
         $display("FAIL match_porches hf=%0d hs=%0d hb=%0d vf=%0d vs=%0d vb=%0d want 88/44/148/4/5/36",
                  out_h_front, out_h_sync, out_h_back,
                  out_v_front, out_v_sync, out_v_back);
      end
   endtask

   task automatic test_lowest();
      for (int b = 0; b <= 2; b += 2) begin
         wr(8'd5, 16'(b));
         wr(8'd6, 16'd720);
         wr(8'd7, 16'd576);
         wr(8'd8, 16'd1);
         wr(8'd15, 16'd1);
      end
      pkt(16'd720, 16'd576, 1'b1);
      tests++;
      if (mode_match !== 4'b0001 || mode_change !== 1'b1) begin
         fails++;
         $display("FAIL lowest_win match=%b chg=%b want 0001/1",
                  mode_match, mode_change);
      end
      pkt(16'd720, 16'd576, 1'b1);
      tests++;
      if (mode_match !== 4'b0001 || mode_change !== 1'b0) begin
         fails++;
         $display("FAIL repeat_no_change match=%b chg=%b want 0001/0",
                  mode_match, mode_change);
      end
   endtask

   task automatic test_bad_select();
      // wr_bank is 2 here; select 7 must be ignored.
      wr(8'd5, 16'd7);
      wr(8'd6, 16'd100);
      pkt(16'd100, 16'd576, 1'b1);
      tests++;
      if (mode_match !== 4'b0100 || mode_change !== 1'b1) begin
         fails++;
         $display("FAIL bad_select match=%b chg=%b want 0100/1",
                  mode_match, mode_change);
      end
      fs();
      tests++;
      if (out_h_active !== 16'd100 || out_interlaced !== 1'b1) begin
         fails++;
         $display("FAIL bad_select_out ha=%0d il=%b want 100/1",
                  out_h_active, out_interlaced);
      end
   endtask

   task automatic test_back_to_back();
      wr(8'd5, 16'd3);
      @(negedge clk);
      write_trigger = 1'b1;
      av_address    = 8'd6;
      av_writedata  = 16'd800;
      @(negedge clk);
      tests++;
      if (av_write_ack !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ack1 got %b want 1", av_write_ack);
      end
      @(negedge clk);
      tests++;
      if (av_write_ack !== 1'b0) begin
         fails++;
         $display("FAIL b2b_gap got %b want 0", av_write_ack);
      end
      av_address   = 8'd7;
      av_writedata = 16'd600;
      @(negedge clk);
      tests++;
      if (av_write_ack !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ack2 got %b want 1", av_write_ack);
      end
      write_trigger = 1'b0;
      @(negedge clk);
      wr(8'd8, 16'd0);
      wr(8'd15, 16'd1);
      pkt(16'd800, 16'd600, 1'b0);
      tests++;
      if (mode_match !== 4'b1000) begin
         fails++;
         $display("FAIL b2b_match got %b want 1000", mode_match);
      end
      fs();
      tests++;
      if (out_h_active !== 16'd800 || out_v_active !== 16'd600) begin
         fails++;
         $display("FAIL b2b_out ha=%0d va=%0d want 800/600",
                  out_h_active, out_v_active);
      end
   endtask

   task automatic test_unmatched();
      pkt(16'd640, 16'd480, 1'b0);
      tests++;
      if (mode_match !== 4'b0000 || mode_change !== 1'b1) begin
         fails++;
         $display("FAIL unmatched match=%b chg=%b want 0000/1",
                  mode_match, mode_change);
      end
      fs();
      tests++;
      if (out_valid !== 1'b0 || out_h_active !== 16'd800) begin
         fails++;
         $display("FAIL unmatched_out vld=%b ha=%0d want 0/800",
                  out_valid, out_h_active);
      end
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      rst_n         = 1'b0;
      write_trigger = 1'b0;
      av_address    = '0;
      av_writedata  = '0;
      is_ctrl_valid = 1'b0;
      is_width      = '0;
      is_height     = '0;
      is_interlaced = 1'b0;
      frame_start   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_match();
      test_lowest();
      test_bad_select();
      test_back_to_back();
      test_unmatched();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
